// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its neighbours: time/alarm buses,
// arm switch, debounced button pulses and the alarm status outputs.
interface alarm_sequencer_if;
    logic        en;
    logic [11:0] time_in;
    logic [11:0] alarm_in;
    logic        snooze;
    logic        stop;
    logic [1:0]  state;
    logic        ringing;
    logic [3:0]  snooze_left;
    logic [4:0]  led;

    // All inputs are sampled on the rising clock edge. snooze and stop are one-cycle pulses.
    // Outputs change only after that edge.
    modport master (
        output en, time_in, alarm_in, snooze, stop,
        input  state, ringing, snooze_left, led
    );

    modport slave (
        input  en, time_in, alarm_in, snooze, stop,
        output state, ringing, snooze_left, led
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm controller: matches the running time against the alarm time and sequences
// the armed / ringing / snoozed cycle with minute-tick timeouts and an LED blink.
module alarm_sequencer #(
    parameter int SYS_FREQ         = 100000000,
    parameter int BLINK_DIV        = 25000000,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic             clk,
    input  logic             rst,
    alarm_sequencer_if.slave bus
);
    if (SYS_FREQ < 1 || BLINK_DIV < 1 || BLINK_DIV > 33554432 ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 15 ||
        RING_TIMEOUT_MIN < 1 || RING_TIMEOUT_MIN > 15) begin : g_param_check
        $error("alarm_sequencer: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        RING   = 2'b10,
        SNOOZE = 2'b11
    } state_t;

    localparam logic [3:0]  SNOOZE_LOAD = 4'(SNOOZE_MIN);
    localparam logic [3:0]  TIMEOUT     = 4'(RING_TIMEOUT_MIN);
    localparam logic [25:0] BLINK_LAST  = 26'(BLINK_DIV - 1);

    state_t      st;
    logic [11:0] prev_time;
    logic        tick_valid;
    logic        fired;
    logic [3:0]  ring_cnt;
    logic [3:0]  snooze_cnt;
    logic [25:0] blink_cnt;
    logic        phase;
    logic        tick;
    logic        match;

    assign tick  = tick_valid && (bus.time_in != prev_time);
    assign match = (bus.time_in == bus.alarm_in);

    always_ff @(posedge clk) begin
        prev_time <= bus.time_in;
        if (rst) begin
            st         <= IDLE;
            tick_valid <= 1'b0;
            fired      <= 1'b0;
            ring_cnt   <= 4'd0;
            snooze_cnt <= 4'd0;
            blink_cnt  <= 26'd0;
            phase      <= 1'b0;
        end else begin
            tick_valid <= 1'b1;
            // fired only remembers the current matching minute
            if (!match) fired <= 1'b0;
            if (!bus.en) begin
                st         <= IDLE;
                ring_cnt   <= 4'd0;
                snooze_cnt <= 4'd0;
                blink_cnt  <= 26'd0;
                phase      <= 1'b0;
            end else begin
                case (st)
                    IDLE: st <= ARMED;
                    ARMED: begin
                        if (match && !fired) begin
                            st        <= RING;
                            fired     <= 1'b1;
                            ring_cnt  <= 4'd0;
                            blink_cnt <= 26'd0;
                            phase     <= 1'b1;
                        end
                    end
                    RING: begin
                        if (bus.stop || (!bus.snooze && tick && (ring_cnt + 4'd1 == TIMEOUT))) begin
                            st        <= ARMED;
                            ring_cnt  <= 4'd0;
                            blink_cnt <= 26'd0;
                            phase     <= 1'b0;
                        end else if (bus.snooze) begin
                            st         <= SNOOZE;
                            snooze_cnt <= SNOOZE_LOAD;
                            ring_cnt   <= 4'd0;
                            blink_cnt  <= 26'd0;
                            phase      <= 1'b0;
                        end else begin
                            if (tick) ring_cnt <= ring_cnt + 4'd1;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= 26'd0;
                                phase     <= ~phase;
                            end else begin
                                blink_cnt <= blink_cnt + 26'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (bus.stop) begin
                            st         <= ARMED;
                            snooze_cnt <= 4'd0;
                        end else if (tick) begin
                            // snooze expiry returns straight to RING without re-checking match
                            if (snooze_cnt == 4'd1) begin
                                st         <= RING;
                                snooze_cnt <= 4'd0;
                                ring_cnt   <= 4'd0;
                                blink_cnt  <= 26'd0;
                                phase      <= 1'b1;
                            end else begin
                                snooze_cnt <= snooze_cnt - 4'd1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.state       = st;
    assign bus.ringing     = (st == RING);
    assign bus.snooze_left = snooze_cnt;

    always_comb begin
        bus.led = 5'b00000;
        case (st)
            ARMED:   bus.led = 5'b00001;
            SNOOZE:  bus.led = 5'b00010;
            RING:    bus.led = {5{phase}};
            default: bus.led = 5'b00000;
        endcase
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table, hand sequences for blink,
// timeout and re-trigger, then random stimulus against a behavioural model.
module tb_alarm_sequencer;
    localparam int BLINK_DIV        = 4;
    localparam int SNOOZE_MIN       = 2;
    localparam int RING_TIMEOUT_MIN = 3;
    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_RING   = 2;
    localparam int M_SNOOZE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .SYS_FREQ(100000000),
        .BLINK_DIV(BLINK_DIV),
        .SNOOZE_MIN(SNOOZE_MIN),
        .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic [11:0] t;
        logic [11:0] a;
        logic        sn;
        logic        st;
        logic [1:0]  e_state;
        logic [4:0]  e_led;
        logic [3:0]  e_sl;
    } vec_t;
    vec_t tbl[$];

    // Behavioural model: mode, matched-minute memory, tick counts and cycles spent ringing.
    int          m_mode;
    bit          m_fired;
    int          m_ring_ticks;
    int          m_snooze;
    int          m_age;
    logic [11:0] m_prev;
    bit          m_tick_ok;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [11:0] t,
                              input logic [11:0] a, input logic sn, input logic st);
        bit tick;
        bit match;
        int nxt;
        if (r) begin
            m_mode = M_IDLE; m_fired = 0; m_ring_ticks = 0; m_snooze = 0;
            m_age = 0; m_tick_ok = 0; m_prev = t;
            return;
        end
        tick  = m_tick_ok && (t != m_prev);
        match = (t == a);
        nxt   = m_mode;
        if (!match) m_fired = 0;
        if (!e) nxt = M_IDLE;
        else begin
            case (m_mode)
                M_IDLE: nxt = M_ARMED;
                M_ARMED: if (match && !m_fired) begin
                    nxt = M_RING; m_fired = 1; m_ring_ticks = 0;
                end
                M_RING: begin
                    if (st) nxt = M_ARMED;
                    else if (sn) begin nxt = M_SNOOZE; m_snooze = SNOOZE_MIN; end
                    else if (tick) begin
                        m_ring_ticks++;
                        if (m_ring_ticks == RING_TIMEOUT_MIN) nxt = M_ARMED;
                    end
                end
                default: begin
                    if (st) nxt = M_ARMED;
                    else if (tick) begin
                        m_snooze--;
                        if (m_snooze == 0) begin nxt = M_RING; m_ring_ticks = 0; end
                    end
                end
            endcase
        end
        if (nxt == M_RING) m_age = (m_mode == M_RING) ? m_age + 1 : 0;
        else m_age = 0;
        if (nxt != M_SNOOZE) m_snooze = 0;
        m_mode = nxt; m_prev = t; m_tick_ok = 1;
    endtask

    function automatic logic [4:0] model_led();
        case (m_mode)
            M_ARMED:  return 5'b00001;
            M_SNOOZE: return 5'b00010;
            M_RING:   return (((m_age / BLINK_DIV) % 2) == 0) ? 5'b11111 : 5'b00000;
            default:  return 5'b00000;
        endcase
    endfunction

    task automatic apply(input logic r, input logic e, input logic [11:0] t,
                         input logic [11:0] a, input logic sn, input logic st);
        rst = r; bus.en = e; bus.time_in = t; bus.alarm_in = a;
        bus.snooze = sn; bus.stop = st;
        @(posedge clk);
        model_edge(r, e, t, a, sn, st);
        #1;
        chk("model_state", {6'd0, bus.state}, 8'(m_mode));
        chk("model_ringing", {7'd0, bus.ringing}, {7'd0, m_mode == M_RING});
        chk("model_led", {3'd0, bus.led}, {3'd0, model_led()});
        chk("model_snooze_left", {4'd0, bus.snooze_left}, 8'(m_snooze));
    endtask

    task automatic add(input logic r, input logic e, input logic [11:0] t, input logic sn,
                       input logic st, input logic [1:0] es, input logic [4:0] el, input logic [3:0] esl);
        vec_t v;
        v.r = r; v.e = e; v.t = t; v.a = 12'h715; v.sn = sn; v.st = st;
        v.e_state = es; v.e_led = el; v.e_sl = esl;
        tbl.push_back(v);
    endtask

    initial begin
        logic [11:0] cur_t;
        logic [11:0] cur_a;
        logic        cur_en;
        logic [11:0] t_set [4];
        t_set[0] = 12'h714; t_set[1] = 12'h715; t_set[2] = 12'h716; t_set[3] = 12'h717;

        //   rst en  time     sn st  state  led       snooze_left
        add(1, 1, 12'h714, 0, 0, 2'b00, 5'b00000, 4'd0);
        add(0, 1, 12'h714, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(0, 1, 12'h715, 0, 1, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h716, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(0, 1, 12'h715, 1, 0, 2'b11, 5'b00010, 4'd2);
        add(0, 1, 12'h715, 1, 0, 2'b11, 5'b00010, 4'd2);
        add(0, 1, 12'h716, 0, 0, 2'b11, 5'b00010, 4'd1);
        add(0, 1, 12'h717, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(0, 1, 12'h717, 1, 1, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(0, 1, 12'h715, 1, 0, 2'b11, 5'b00010, 4'd2);
        add(0, 0, 12'h715, 0, 0, 2'b00, 5'b00000, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h716, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);
        add(1, 1, 12'h715, 0, 0, 2'b00, 5'b00000, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b01, 5'b00001, 4'd0);
        add(0, 1, 12'h715, 0, 0, 2'b10, 5'b11111, 4'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].a, tbl[i].sn, tbl[i].st);
            chk($sformatf("tbl%0d_state", i), {6'd0, bus.state}, {6'd0, tbl[i].e_state});
            chk($sformatf("tbl%0d_led", i), {3'd0, bus.led}, {3'd0, tbl[i].e_led});
            chk($sformatf("tbl%0d_snooze_left", i), {4'd0, bus.snooze_left}, {4'd0, tbl[i].e_sl});
        end

        // Blink: 4 cycles lit, 4 dark, starting from the entry cycle above
        for (int i = 1; i <= 12; i++) begin
            apply(0, 1, 12'h715, 12'h715, 0, 0);
            chk($sformatf("blink%0d", i), {3'd0, bus.led}, (((i / 4) % 2) == 0) ? 8'h1f : 8'h00);
        end

        // Auto-stop on the third minute tick of unattended ringing
        apply(0, 1, 12'h716, 12'h715, 0, 0);
        chk("timeout_tick1", {6'd0, bus.state}, 8'd2);
        apply(0, 1, 12'h716, 12'h715, 0, 0);
        apply(0, 1, 12'h717, 12'h715, 0, 0);
        chk("timeout_tick2", {6'd0, bus.state}, 8'd2);
        apply(0, 1, 12'h718, 12'h715, 0, 0);
        chk("timeout_tick3", {6'd0, bus.state}, 8'd1);
        chk("timeout_led", {3'd0, bus.led}, 8'h01);

        // No re-trigger within the matching minute after stop
        apply(0, 1, 12'h715, 12'h715, 0, 0);
        chk("retrig_ring", {6'd0, bus.state}, 8'd2);
        apply(0, 1, 12'h715, 12'h715, 0, 1);
        for (int i = 0; i < 100; i++) begin
            apply(0, 1, 12'h715, 12'h715, 0, 0);
            chk("hold_armed", {6'd0, bus.state}, 8'd1);
        end
        apply(0, 1, 12'h716, 12'h715, 0, 0);
        apply(0, 1, 12'h715, 12'h715, 0, 0);
        chk("rering", {6'd0, bus.state}, 8'd2);

        // Random stimulus against the model
        cur_t = 12'h715; cur_a = 12'h715; cur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur_t = t_set[$urandom_range(0, 3)];
            if ($urandom_range(0, 199) == 0) cur_a = t_set[$urandom_range(0, 2)];
            if ($urandom_range(0, 59) == 0) cur_en = ~cur_en;
            apply($urandom_range(0, 199) == 0, cur_en, cur_t, cur_a,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
